// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce,
// and a 4-digit hex entry shift register feeding the seven-segment display.
module keypad_scan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_CYCLES    = 4
) (
  input  logic        IN_clk,
  input  logic        IN_rst,
  input  logic [3:0]  IN_row,
  input  logic        IN_clear,
  output logic [3:0]  OUT_col,
  output logic [3:0]  OUT_key,
  output logic        OUT_valid,
  output logic        OUT_pressed,
  output logic [15:0] OUT_value
);

  localparam logic [15:0] DEB_MAX    = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_row_p0;
  logic [3:0]  r_row_p1;
  logic [1:0]  r_col;
  logic [15:0] r_dwell;
  logic [15:0] r_cnt;
  logic [3:0]  r_pat;
  logic [3:0]  r_key;
  logic        r_valid;
  logic        r_pressed;
  logic [15:0] r_value;

  logic [3:0]  w_srow;
  logic        w_dwell_end;
  logic [3:0]  w_code;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_cnt_nxt;
  logic        w_col_adv;
  logic        w_dwell_clr;
  logic        w_pat_load;
  logic        w_accept;
  logic        w_pressed_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c >= DEB_MAX) ? DEB_MAX : c + 16'd1;
  endfunction

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] s);
    logic [3:0] z;
    z = ~s;
    return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!p[r]) idx = 2'(r);
    end
    return idx;
  endfunction

  assign w_srow      = r_row_p1;
  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_code      = {row_index(r_pat), r_col};
  assign w_cnt_inc   = sat_inc(r_cnt);

  assign OUT_col     = ~(4'b0001 << r_col);
  assign OUT_key     = r_key;
  assign OUT_valid   = r_valid;
  assign OUT_pressed = r_pressed;
  assign OUT_value   = r_value;

  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) r_state <= S_SCAN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_col_adv     = 1'b0;
    w_dwell_clr   = 1'b0;
    w_pat_load    = 1'b0;
    w_accept      = 1'b0;
    w_pressed_nxt = 1'b0;
    unique case (r_state)
      S_SCAN: begin
        if (w_dwell_end) begin
          w_dwell_clr = 1'b1;
          // All-high and multi-key columns both fall through to the next column.
          if (single_low(w_srow)) begin
            w_pat_load  = 1'b1;
            w_cnt_nxt   = 16'd1;
            w_state_nxt = S_DEBOUNCE;
          end else begin
            w_col_adv = 1'b1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (w_srow == r_pat) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == DEB_MAX) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HELD;
          end
        end else begin
          w_cnt_nxt   = 16'd0;
          w_dwell_clr = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_HELD: begin
        w_pressed_nxt = 1'b1;
        if (w_srow == 4'hF) begin
          w_cnt_nxt   = 16'd1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_pressed_nxt = 1'b1;
        if (w_srow != 4'hF) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = S_HELD;
        end else if (w_cnt_inc == DEB_MAX) begin
          w_cnt_nxt     = 16'd0;
          w_col_adv     = 1'b1;
          w_dwell_clr   = 1'b1;
          w_pressed_nxt = 1'b0;
          w_state_nxt   = S_SCAN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      r_row_p0  <= 4'hF;
      r_row_p1  <= 4'hF;
      r_col     <= 2'd0;
      r_dwell   <= 16'd0;
      r_cnt     <= 16'd0;
      r_pat     <= 4'hF;
      r_key     <= 4'h0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
      r_value   <= 16'h0000;
    end else begin
      // Row synchronizer boundary
      r_row_p0 <= IN_row;
      r_row_p1 <= r_row_p0;
      r_cnt    <= w_cnt_nxt;
      if (w_dwell_clr)            r_dwell <= 16'd0;
      else if (r_state == S_SCAN) r_dwell <= r_dwell + 16'd1;
      if (w_col_adv)  r_col <= r_col + 2'd1;
      if (w_pat_load) r_pat <= w_srow;
      r_valid   <= w_accept;
      r_pressed <= w_pressed_nxt;
      if (w_accept) r_key <= w_code;
      // Clear wins over the shift, but a coincident accept still lands in [3:0].
      if (IN_clear)      r_value <= w_accept ? {12'h000, w_code} : 16'h0000;
      else if (w_accept) r_value <= {r_value[11:0], w_code};
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix.
module tb_keypad_scan;

  logic        IN_clk;
  logic        IN_rst;
  logic [3:0]  IN_row;
  logic        IN_clear;
  logic [3:0]  OUT_col;
  logic [3:0]  OUT_key;
  logic        OUT_valid;
  logic        OUT_pressed;
  logic [15:0] OUT_value;

  logic [15:0] key_down;
  int          n_tests;
  int          n_fail;

  keypad_scan #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (4)
  ) dut (
    .IN_clk     (IN_clk),
    .IN_rst     (IN_rst),
    .IN_row     (IN_row),
    .IN_clear   (IN_clear),
    .OUT_col    (OUT_col),
    .OUT_key    (OUT_key),
    .OUT_valid  (OUT_valid),
    .OUT_pressed(OUT_pressed),
    .OUT_value  (OUT_value)
  );

  initial IN_clk = 1'b0;
  always #5 IN_clk = ~IN_clk;

  // Key index r*4+c pulls row r low while column c is driven low.
  always_comb begin
    IN_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !OUT_col[c]) IN_row[r] = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge IN_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},     16'(OUT_col),     16'hE);
    check({tag, "_key"},     16'(OUT_key),     16'h0);
    check({tag, "_valid"},   16'(OUT_valid),   16'h0);
    check({tag, "_pressed"}, 16'(OUT_pressed), 16'h0);
    check({tag, "_value"},   OUT_value,        16'h0000);
  endtask

  task automatic wait_col(input logic [3:0] c);
    int w;
    w = 0;
    while (OUT_col !== c && w < 40) begin
      @(negedge IN_clk);
      w++;
    end
    check("wait_col", 16'(OUT_col), 16'(c));
  endtask

  task automatic count_valid(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge IN_clk);
      if (OUT_valid === 1'b1) pulses++;
    end
  endtask

  // Press, hold, release one key; expect exactly one accept with given key/value.
  task automatic do_key(input int key, input int hold, input logic clr,
                        input logic [3:0] exp_key, input logic [15:0] exp_val,
                        input string tag);
    int          pulses;
    int          w;
    logic [3:0]  k;
    logic [15:0] v;
    logic        prev_v;
    logic        pr_after;
    pulses = 0; k = 4'h0; v = 16'h0; prev_v = 1'b0; pr_after = 1'b0;
    key_down[key] = 1'b1;
    IN_clear = clr;
    for (int i = 0; i < hold; i++) begin
      @(negedge IN_clk);
      if (prev_v) pr_after = OUT_pressed;
      prev_v = OUT_valid;
      if (OUT_valid === 1'b1) begin
        pulses++;
        k = OUT_key;
        v = OUT_value;
        IN_clear = 1'b0;
      end
    end
    IN_clear = 1'b0;
    key_down[key] = 1'b0;
    w = 0;
    while (OUT_pressed === 1'b1 && w < 100) begin
      @(negedge IN_clk);
      if (OUT_valid === 1'b1) pulses++;
      w++;
    end
    check({tag, "_pulses"},   16'(pulses),      16'd1);
    check({tag, "_key"},      16'(k),           16'(exp_key));
    check({tag, "_value"},    v,                exp_val);
    check({tag, "_pr_after"}, 16'(pr_after),    16'd1);
    check({tag, "_released"}, 16'(OUT_pressed), 16'd0);
  endtask

  initial begin
    int          pulses;
    logic [3:0]  exp_col;
    n_tests  = 0;
    n_fail   = 0;
    key_down = 16'h0000;
    IN_clear = 1'b0;
    IN_rst   = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    IN_rst = 1'b0;

    // Idle scan: each column held for 4 clocks, no accepts.
    pulses = 0;
    for (int k = 0; k < 64; k++) begin
      exp_col = 4'b0001 << ((k / 4) % 4);
      exp_col = ~exp_col;
      check("idle_col", 16'(OUT_col), 16'(exp_col));
      if (OUT_valid === 1'b1) pulses++;
      @(negedge IN_clk);
    end
    check("idle_valid", 16'(pulses), 16'd0);
    check("idle_value", OUT_value, 16'h0000);

    // Clean press: row 2, column 1.
    do_key(9, 30, 1'b0, 4'h9, 16'h0009, "press9");

    // Bouncing row 0 on column 3, then steady.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      key_down[3] = ~key_down[3];
      for (int j = 0; j < 2; j++) begin
        @(negedge IN_clk);
        if (OUT_valid === 1'b1) pulses++;
      end
    end
    check("bounce_nopulse", 16'(pulses), 16'd0);
    do_key(3, 30, 1'b0, 4'h3, 16'h0093, "bounce3");

    // Clear, then entry 1..5.
    IN_clear = 1'b1;
    tick(1);
    IN_clear = 1'b0;
    check("clear_value", OUT_value, 16'h0000);
    do_key(1, 30, 1'b0, 4'h1, 16'h0001, "entry1");
    do_key(2, 30, 1'b0, 4'h2, 16'h0012, "entry2");
    do_key(3, 30, 1'b0, 4'h3, 16'h0123, "entry3");
    do_key(4, 30, 1'b0, 4'h4, 16'h1234, "entry4");
    do_key(5, 30, 1'b0, 4'h5, 16'h2345, "entry5");

    // Clear held across the accept of key 7.
    do_key(7, 30, 1'b1, 4'h7, 16'h0007, "clr7");

    // Rows 0 and 1 together on column 2.
    key_down[2] = 1'b1;
    key_down[6] = 1'b1;
    count_valid(60, pulses);
    check("multi_pulses",  16'(pulses),      16'd0);
    check("multi_pressed", 16'(OUT_pressed), 16'd0);
    check("multi_value",   OUT_value,        16'h0007);
    key_down = 16'h0000;
    tick(4);

    // Reset during DEBOUNCE: key 5 pressed right as column 1 is driven.
    wait_col(4'b1110);
    wait_col(4'b1101);
    key_down[5] = 1'b1;
    tick(5);
    check("deb_valid", 16'(OUT_valid), 16'd0);
    check("deb_col",   16'(OUT_col),   16'hD);
    IN_rst = 1'b1;
    #1;
    check_reset_outputs("rst_deb");
    key_down = 16'h0000;
    tick(2);
    IN_rst = 1'b0;
    count_valid(40, pulses);
    check("rst_deb_nopulse", 16'(pulses), 16'd0);

    // Exact accept latency for key 6, then reset during HELD.
    wait_col(4'b1101);
    wait_col(4'b1011);
    key_down[6] = 1'b1;
    tick(6);
    check("lat_before", 16'(OUT_valid), 16'd0);
    tick(1);
    check("lat_valid", 16'(OUT_valid), 16'd1);
    check("lat_key",   16'(OUT_key),   16'h6);
    check("lat_value", OUT_value,      16'h0006);
    tick(1);
    check("lat_valid_end", 16'(OUT_valid),   16'd0);
    check("lat_pressed",   16'(OUT_pressed), 16'd1);
    tick(3);
    check("held_pressed", 16'(OUT_pressed), 16'd1);
    IN_rst = 1'b1;
    #1;
    check_reset_outputs("rst_held");
    key_down = 16'h0000;
    tick(2);
    IN_rst = 1'b0;
    count_valid(40, pulses);
    check("rst_held_nopulse", 16'(pulses),      16'd0);
    check("rst_held_pressed", 16'(OUT_pressed), 16'd0);

    do_key(10, 30, 1'b0, 4'hA, 16'h000A, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
